// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_pkg;

  // Debounce FSM encoding; the top keeps plain 2-bit constants derived from it.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // 10 ms settle window and 1 s long-press threshold at the 27 MHz board clock.
  localparam int KEY_STABLE_CYCLES_DFLT = 270000;
  localparam int KEY_LONG_CYCLES_DFLT   = 27000000;
  localparam int KEY_CNT_W_DFLT         = 25;

endpackage

// File: rtl/key_debouncer_if.sv
// Button-side bundle: raw active-low input in, cleaned level and pulses out.
interface key_debouncer_if;

  logic iKEYn;     // raw button, 0 = pressed, asynchronous to the clock
  logic oKEY;      // debounced level, 1 = pressed
  logic oPRESS;    // one-cycle pulse on accepted press
  logic oRELEASE;  // one-cycle pulse on accepted release
  logic oLONG;     // one-cycle pulse once per press at the hold threshold

  // Driver of the raw key (board model or bench).
  modport master (
    output iKEYn,
    input  oKEY,
    input  oPRESS,
    input  oRELEASE,
    input  oLONG
  );

  // The debouncer itself.
  modport slave (
    input  iKEYn,
    output oKEY,
    output oPRESS,
    output oRELEASE,
    output oLONG
  );

endinterface

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the async input and give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizes an active-low key, confirms each level
// change over STABLE_CYCLES samples, and emits press/release/long-press pulses.
module key_debouncer
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES_DFLT,
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES_DFLT,
  parameter int CNT_W         = KEY_CNT_W_DFLT
) (
  input  logic     CLK,
  input  logic     RESET,
  key_debouncer_if.slave bus
);

  localparam logic [1:0] ST_RELEASED    = RELEASED;
  localparam logic [1:0] ST_PRESS_CHK   = PRESS_CHK;
  localparam logic [1:0] ST_PRESSED     = PRESSED;
  localparam logic [1:0] ST_RELEASE_CHK = RELEASE_CHK;

  // Terminal counts; both fit in CNT_W bits because the limits are <= 2^CNT_W.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);

  logic             w_sync_q;
  logic             w_s;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_long_done;
  logic             w_press;
  logic             w_release;
  logic             w_holding;
  logic             w_long;
  logic             r_key;
  logic             r_press;
  logic             r_release;
  logic             r_long;

  // Released level is 1 on the raw pin, so the synchronizer resets to 1.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (CLK),
    .rst (RESET),
    .i_d (bus.iKEYn),
    .o_q (w_sync_q)
  );

  assign w_s = ~w_sync_q;

  // Next-state and stable-counter logic; cnt restarts on every CHK entry so it
  // never exceeds STABLE_LAST and cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_s) begin
          w_state_nxt = ST_PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASED;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_CHK;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (w_s) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RELEASED;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The hold timer keeps running through a release bounce, so the key counts
  // as held in both PRESSED and RELEASE_CHK.
  assign w_holding = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_CHK);
  assign w_long    = w_holding && (r_hcnt == LONG_LAST) && !r_long_done;

  // FSM state and stable counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Hold counter saturates at the threshold; long-done limits oLONG to once per press.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hcnt      <= '0;
      r_long_done <= 1'b0;
    end else if (w_press) begin
      r_hcnt      <= '0;
      r_long_done <= 1'b0;
    end else begin
      if (w_holding && (r_hcnt != LONG_LAST)) begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end
      if (w_long) begin
        r_long_done <= 1'b1;
      end
    end
  end

  // Registered outputs; the level follows the next state so it lines up with the pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_key     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_key     <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_CHK);
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
    end
  end

  assign bus.oKEY     = r_key;
  assign bus.oPRESS   = r_press;
  assign bus.oRELEASE = r_release;
  assign bus.oLONG    = r_long;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4, LONG_CYCLES=20.
module tb_key_debouncer;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_pass;

  // pat[k] is the raw key value sampled at edge k of a run;
  // rec[k] = {oKEY, oPRESS, oRELEASE, oLONG} seen just after edge k.
  logic       pat [1:64];
  logic [3:0] rec [1:64];

  key_debouncer_if kif ();

  key_debouncer #(
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (20),
    .CNT_W         (5)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (kif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive pat[1..n] one per edge and record outputs 1 time unit after each edge.
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      kif.iKEYn = pat[k];
      @(posedge CLK);
      #1;
      rec[k] = {kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG};
    end
  endtask

  task automatic fill(input int from, input int to, input logic v);
    for (int k = from; k <= to; k++) pat[k] = v;
  endtask

  function automatic int first_of(input int b, input int n);
    for (int k = 1; k <= n; k++) if (rec[k][b]) return k;
    return 0;
  endfunction

  function automatic int count_of(input int b, input int n);
    int c;
    c = 0;
    for (int k = 1; k <= n; k++) if (rec[k][b]) c++;
    return c;
  endfunction

  task automatic test_reset();
    int c;
    RESET = 1'b1;
    kif.iKEYn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG} !== 4'b0000)
      $display("FAIL reset_outputs got=%b want=0000", {kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG});
    else n_pass++;
    RESET = 1'b0;
    fill(1, 50, 1'b1);
    run(50);
    c = count_of(0, 50) + count_of(1, 50) + count_of(2, 50) + count_of(3, 50);
    n_checks++;
    if (c !== 0) $display("FAIL idle_outputs high_samples=%0d want=0", c);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    fill(1, 12, 1'b0);
    run(12);
    n_checks++;
    if (first_of(2, 12) !== 7) $display("FAIL press_edge got=%0d want=7", first_of(2, 12));
    else n_pass++;
    n_checks++;
    if (count_of(2, 12) !== 1) $display("FAIL press_width got=%0d want=1", count_of(2, 12));
    else n_pass++;
    n_checks++;
    if (first_of(3, 12) !== 7 || count_of(3, 12) !== 6)
      $display("FAIL press_level first=%0d cnt=%0d want=7/6", first_of(3, 12), count_of(3, 12));
    else n_pass++;
    n_checks++;
    if (count_of(1, 12) !== 0) $display("FAIL press_no_release got=%0d want=0", count_of(1, 12));
    else n_pass++;
    fill(1, 12, 1'b1);
    run(12);
    n_checks++;
    if (first_of(1, 12) !== 7 || count_of(1, 12) !== 1)
      $display("FAIL release_edge first=%0d cnt=%0d want=7/1", first_of(1, 12), count_of(1, 12));
    else n_pass++;
    n_checks++;
    if (count_of(3, 12) !== 6 || rec[7][3] !== 1'b0)
      $display("FAIL release_level cnt=%0d want=6", count_of(3, 12));
    else n_pass++;
    n_checks++;
    if (count_of(0, 12) !== 0) $display("FAIL short_hold_long got=%0d want=0", count_of(0, 12));
    else n_pass++;
  endtask

  task automatic test_bounce();
    // Press-side bounce: 3 low, 2 high, five times, then idle high.
    for (int r = 0; r < 5; r++) begin
      fill(r * 5 + 1, r * 5 + 3, 1'b0);
      fill(r * 5 + 4, r * 5 + 5, 1'b1);
    end
    fill(26, 35, 1'b1);
    run(35);
    n_checks++;
    if (count_of(2, 35) + count_of(1, 35) + count_of(0, 35) !== 0)
      $display("FAIL bounce_press_pulses got=%0d want=0", count_of(2, 35) + count_of(1, 35) + count_of(0, 35));
    else n_pass++;
    n_checks++;
    if (count_of(3, 35) !== 0) $display("FAIL bounce_press_level got=%0d want=0", count_of(3, 35));
    else n_pass++;
    fill(1, 10, 1'b0);
    run(10);
    n_checks++;
    if (first_of(2, 10) !== 7) $display("FAIL bounce_real_press got=%0d want=7", first_of(2, 10));
    else n_pass++;
    // Release-side bounce: 3 high, 2 low, five times, then held low.
    for (int r = 0; r < 5; r++) begin
      fill(r * 5 + 1, r * 5 + 3, 1'b1);
      fill(r * 5 + 4, r * 5 + 5, 1'b0);
    end
    fill(26, 35, 1'b0);
    run(35);
    n_checks++;
    if (count_of(3, 35) !== 35) $display("FAIL bounce_release_level got=%0d want=35", count_of(3, 35));
    else n_pass++;
    n_checks++;
    if (count_of(1, 35) + count_of(2, 35) !== 0)
      $display("FAIL bounce_release_pulses got=%0d want=0", count_of(1, 35) + count_of(2, 35));
    else n_pass++;
    fill(1, 12, 1'b1);
    run(12);
    n_checks++;
    if (first_of(1, 12) !== 7) $display("FAIL bounce_real_release got=%0d want=7", first_of(1, 12));
    else n_pass++;
  endtask

  task automatic test_long_press();
    fill(1, 40, 1'b0);
    run(40);
    n_checks++;
    if (first_of(2, 40) !== 7 || count_of(2, 40) !== 1)
      $display("FAIL long_press_pulse first=%0d cnt=%0d want=7/1", first_of(2, 40), count_of(2, 40));
    else n_pass++;
    n_checks++;
    if (first_of(0, 40) !== 27) $display("FAIL long_edge got=%0d want=27", first_of(0, 40));
    else n_pass++;
    n_checks++;
    if (count_of(0, 40) !== 1) $display("FAIL long_once got=%0d want=1", count_of(0, 40));
    else n_pass++;
    fill(1, 12, 1'b1);
    run(12);
    n_checks++;
    if (first_of(1, 12) !== 7 || count_of(1, 12) !== 1)
      $display("FAIL long_release first=%0d cnt=%0d want=7/1", first_of(1, 12), count_of(1, 12));
    else n_pass++;
    n_checks++;
    if (count_of(0, 12) !== 0) $display("FAIL long_after_release got=%0d want=0", count_of(0, 12));
    else n_pass++;
  endtask

  task automatic test_release_at_threshold();
    // First high sample at edge 21 confirms the release at edge 27 = long edge.
    fill(1, 20, 1'b0);
    fill(21, 30, 1'b1);
    run(30);
    n_checks++;
    if (rec[27][1:0] !== 2'b11) $display("FAIL thresh_both got=%b want=11", rec[27][1:0]);
    else n_pass++;
    n_checks++;
    if (count_of(0, 30) !== 1 || count_of(1, 30) !== 1)
      $display("FAIL thresh_counts long=%0d rel=%0d want=1/1", count_of(0, 30), count_of(1, 30));
    else n_pass++;
    n_checks++;
    if (count_of(3, 30) !== 20) $display("FAIL thresh_level got=%0d want=20", count_of(3, 30));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while in PRESS_CHK with cnt=2.
    fill(1, 5, 1'b0);
    run(5);
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG} !== 4'b0000)
      $display("FAIL rst_chk_outputs got=%b want=0000", {kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG});
    else n_pass++;
    fill(1, 3, 1'b0);
    run(3);
    RESET = 1'b0;
    fill(1, 17, 1'b0);
    run(17);
    n_checks++;
    if (first_of(2, 17) !== 7 || count_of(2, 17) !== 1)
      $display("FAIL rst_chk_repress first=%0d cnt=%0d want=7/1", first_of(2, 17), count_of(2, 17));
    else n_pass++;
    // Now PRESSED with hcnt=10: reset again.
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG} !== 4'b0000)
      $display("FAIL rst_hold_outputs got=%b want=0000", {kif.oKEY, kif.oPRESS, kif.oRELEASE, kif.oLONG});
    else n_pass++;
    run(3);
    n_checks++;
    if (count_of(0, 3) + count_of(1, 3) + count_of(2, 3) + count_of(3, 3) !== 0)
      $display("FAIL rst_hold_quiet got=%0d want=0", count_of(0, 3) + count_of(1, 3) + count_of(2, 3) + count_of(3, 3));
    else n_pass++;
    RESET = 1'b0;
    fill(1, 12, 1'b0);
    run(12);
    n_checks++;
    if (first_of(2, 12) !== 7 || count_of(2, 12) !== 1 || count_of(0, 12) !== 0)
      $display("FAIL rst_hold_repress first=%0d cnt=%0d long=%0d want=7/1/0",
               first_of(2, 12), count_of(2, 12), count_of(0, 12));
    else n_pass++;
    fill(1, 12, 1'b1);
    run(12);
    n_checks++;
    if (first_of(1, 12) !== 7) $display("FAIL rst_final_release got=%0d want=7", first_of(1, 12));
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RESET    = 1'b1;
    kif.iKEYn = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_at_threshold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions one raw, active-low push-button input into a clean debounced level plus single-cycle press, release and long-press pulses. It sits directly upstream of the LED blinker stage: its pulses drive the blinker's enable/mode inputs, so bounce and metastability never reach downstream counters. It runs on the same 27 MHz board clock as the blinker.

## Interface
- STABLE_CYCLES, 270000, number of consecutive synchronized samples required to accept a level change (10 ms at 27 MHz); legal range 2..2^CNT_W.
- LONG_CYCLES, 27000000, hold time in cycles for the long-press pulse (1 s at 27 MHz); must be greater than STABLE_CYCLES and at most 2^CNT_W.
- CNT_W, 25, width of both internal counters.
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- iKEYn  in  1  raw button input, asynchronous to CLK; 0 = pressed.
- oKEY  out  1  debounced level; 1 = pressed.
- oPRESS  out  1  one-cycle pulse when a press is accepted.
- oRELEASE  out  1  one-cycle pulse when a release is accepted.
- oLONG  out  1  one-cycle pulse, at most once per press, when the hold reaches LONG_CYCLES.

## Operation
- Synchronizer: 2 flops, both reset to 1 (released). s = second flop, inverted, so s = 1 means pressed.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
- RELEASED: s=1 → PRESS_CHK, stable counter cnt←0.
- PRESS_CHK:
  - s=0 → RELEASED (bounce rejected, no pulse).
  - s=1 and cnt==STABLE_CYCLES-1 → PRESSED, oPRESS←1, hold counter hcnt←0, long-done flag←0.
  - otherwise cnt←cnt+1.
- PRESSED: s=0 → RELEASE_CHK, cnt←0.
- RELEASE_CHK:
  - s=1 → PRESSED (bounce rejected). hcnt is kept, not cleared.
  - s=0 and cnt==STABLE_CYCLES-1 → RELEASED, oRELEASE←1.
  - otherwise cnt←cnt+1.
- hcnt increments in PRESSED and RELEASE_CHK. When hcnt==LONG_CYCLES-1 and the long-done flag is 0: oLONG←1 and long-done←1. hcnt then saturates and does not wrap.
- oKEY is registered: 1 in PRESSED and RELEASE_CHK, 0 otherwise.
- oLONG and oRELEASE may assert in the same cycle; both are legal and must both be emitted.
- Counter arithmetic is unsigned CNT_W bits. Neither counter may wrap.

## Timing
- Reset values: all outputs 0, state RELEASED, cnt=0, hcnt=0, long-done=0, synchronizer flops 1.
- Reset is asynchronous and may arrive mid-debounce or mid-hold. It aborts the operation and produces no pulse.
- Press latency: iKEYn held low from edge 1 onward gives s=1 after edge 2 and PRESS_CHK after edge 3. oPRESS and oKEY go high after edge STABLE_CYCLES+3; oPRESS is high for exactly one cycle.
- Release latency is symmetric: oRELEASE is high, and oKEY falls, after edge STABLE_CYCLES+3 counted from the first edge that samples iKEYn high.
- oLONG asserts LONG_CYCLES edges after the edge that set oPRESS, provided the key is not released first.
- A glitch shorter than STABLE_CYCLES synchronized samples produces no output change.

## Structure
- Shared package key_pkg:
  - state enum key_state_t {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}.
  - default constants KEY_STABLE_CYCLES_DFLT and KEY_LONG_CYCLES_DFLT.
- Sub-module sync_2ff: parameterized reset value, async active-high reset. It is reused for every other board input.
- FSM, counters and output registers are in key_debouncer.

## Test plan
All scenarios use STABLE_CYCLES=4, LONG_CYCLES=20.
- Reset/idle: assert RESET with iKEYn=1 → all outputs 0. Release reset and hold for 50 cycles → outputs stay 0.
- Clean press: drive iKEYn low at edge 1 and hold → oPRESS high for exactly the cycle after edge 7, oKEY high from edge 7. No oRELEASE.
- Bounce rejection: drive iKEYn low for 3 cycles, high for 2, repeat 5 times, then high → no pulse, oKEY stays 0. Repeat the same pattern during a release → oKEY stays 1.
- Long press: hold low for 40 cycles → oPRESS once, oLONG once exactly 20 edges later, no second oLONG. Release → oRELEASE once, after edge 7 of the release.
- Release exactly at the long threshold: time the release so its confirm edge equals hcnt==19 → oLONG and oRELEASE are high in the same cycle.
- Reset mid-operation: assert RESET during PRESS_CHK (cnt=2) and during PRESSED (hcnt=10) → immediate all-zero outputs and no pulses. After reset with iKEYn still low → a fresh press is accepted after 7 edges.
